// File: rtl/key_pkg.sv
// Shared types, constants and helpers for the key event controller.
package key_pkg;

    localparam int         KEY_NUM  = 4;
    localparam logic [3:0] KEY_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2,
        LOCKED  = 2'd3
    } key_state_e;

    typedef enum logic [1:0] {
        KEY_REL   = 2'd0,
        KEY_ONE   = 2'd1,
        KEY_MULTI = 2'd2
    } key_class_e;

    typedef struct packed {
        key_class_e cls;
        logic [1:0] idx;
    } key_sample_t;

    // Keys are active low: one zero bit is a single key, its position is the index.
    function automatic key_sample_t key_classify(input logic [KEY_NUM-1:0] value);
        key_sample_t res;
        case (value)
            KEY_IDLE: begin res.cls = KEY_REL;   res.idx = 2'd0; end
            4'b1110:  begin res.cls = KEY_ONE;   res.idx = 2'd0; end
            4'b1101:  begin res.cls = KEY_ONE;   res.idx = 2'd1; end
            4'b1011:  begin res.cls = KEY_ONE;   res.idx = 2'd2; end
            4'b0111:  begin res.cls = KEY_ONE;   res.idx = 2'd3; end
            default:  begin res.cls = KEY_MULTI; res.idx = 2'd0; end
        endcase
        return res;
    endfunction

    // Turns a key index into the matching pulse bit.
    function automatic logic [KEY_NUM-1:0] key_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/key_event_ctrl_if.sv
// Debounced key input and key command outputs of the key event controller.
interface key_event_ctrl_if;
    import key_pkg::*;

    logic               key_flag;
    logic [KEY_NUM-1:0] key_value;
    logic [KEY_NUM-1:0] key_short;
    logic [KEY_NUM-1:0] key_long;
    logic [KEY_NUM-1:0] key_repeat;
    logic               key_active;
    logic               key_lock;

    modport master (
        output key_flag, key_value,
        input  key_short, key_long, key_repeat, key_active, key_lock
    );

    modport slave (
        input  key_flag, key_value,
        output key_short, key_long, key_repeat, key_active, key_lock
    );

endinterface

// File: rtl/key_hold_timer.sv
// Hold-time counter: clears on request, otherwise counts up; flags the terminal count.
module key_hold_timer #(
    parameter int CNT_W = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] tc_value,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_r;

    // Count register, cleared by the FSM on every threshold and state change.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign tc = (cnt_r == tc_value);

endmodule

// File: rtl/key_event_ctrl.sv
// Turns the debounced key stream into short/long/repeat command pulses,
// allowing only one key at a time and locking out chords until full release.
module key_event_ctrl
    import key_pkg::*;
#(
    parameter int LONG_CYC   = 50_000_000,
    parameter int REPEAT_CYC = 10_000_000,
    parameter bit REPEAT_EN  = 1'b1
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    key_event_ctrl_if.slave kif
);

    localparam int MAX_CYC = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC);
    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYC - 1);

    key_state_e         state_r, state_nxt_s;
    logic [1:0]         idx_r, idx_nxt_s;
    key_sample_t        sample_s;
    logic               same_key_s, flag_eff_s;
    logic               tc_s, clr_s;
    logic [CNT_W-1:0]   tc_value_s;
    logic [KEY_NUM-1:0] short_nxt_s, long_nxt_s, repeat_nxt_s;
    logic [KEY_NUM-1:0] short_r, long_r, repeat_r;
    logic               active_r, lock_r;

    assign sample_s   = key_classify(kif.key_value);
    assign same_key_s = (sample_s.cls == KEY_ONE) && (sample_s.idx == idx_r);
    // A re-flag of the held key's own pattern is treated as if no flag came.
    assign flag_eff_s = kif.key_flag &&
                        !(((state_r == PRESSED) || (state_r == HELD)) && same_key_s);
    assign tc_value_s = (state_r == HELD) ? REPEAT_TC : LONG_TC;

    key_hold_timer #(.CNT_W(CNT_W)) u_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (clr_s),
        .tc_value  (tc_value_s),
        .tc        (tc_s)
    );

    // State and latched key index.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= IDLE;
            idx_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Next state: an effective flag always beats a timer threshold.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (flag_eff_s && (sample_s.cls == KEY_ONE)) begin
                    state_nxt_s = PRESSED;
                end else if (flag_eff_s && (sample_s.cls == KEY_MULTI)) begin
                    state_nxt_s = LOCKED;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PRESSED: begin
                if (flag_eff_s) begin
                    state_nxt_s = (sample_s.cls == KEY_REL) ? IDLE : LOCKED;
                end else if (tc_s) begin
                    state_nxt_s = HELD;
                end else begin
                    state_nxt_s = PRESSED;
                end
            end
            HELD: begin
                if (flag_eff_s) begin
                    state_nxt_s = (sample_s.cls == KEY_REL) ? IDLE : LOCKED;
                end else begin
                    state_nxt_s = HELD;
                end
            end
            LOCKED: begin
                if (flag_eff_s && (sample_s.cls == KEY_REL)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Pulse requests, key latch and timer clear for the coming cycle.
    always_comb begin
        short_nxt_s  = {KEY_NUM{1'b0}};
        long_nxt_s   = {KEY_NUM{1'b0}};
        repeat_nxt_s = {KEY_NUM{1'b0}};
        idx_nxt_s    = idx_r;
        clr_s        = 1'b1;
        case (state_r)
            IDLE: begin
                if (flag_eff_s && (sample_s.cls == KEY_ONE)) begin
                    idx_nxt_s = sample_s.idx;
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            PRESSED: begin
                clr_s = tc_s || (state_nxt_s != PRESSED);
                if (flag_eff_s && (sample_s.cls == KEY_REL)) begin
                    short_nxt_s = key_onehot(idx_r);
                end else if (!flag_eff_s && tc_s) begin
                    long_nxt_s = key_onehot(idx_r);
                end else begin
                    short_nxt_s = {KEY_NUM{1'b0}};
                end
            end
            HELD: begin
                clr_s = tc_s || (state_nxt_s != HELD);
                if (!flag_eff_s && tc_s && (REPEAT_EN == 1'b1)) begin
                    repeat_nxt_s = key_onehot(idx_r);
                end else begin
                    repeat_nxt_s = {KEY_NUM{1'b0}};
                end
            end
            LOCKED:  clr_s = 1'b1;
            default: clr_s = 1'b1;
        endcase
    end

    // Registered outputs; levels follow the state being entered.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            short_r  <= {KEY_NUM{1'b0}};
            long_r   <= {KEY_NUM{1'b0}};
            repeat_r <= {KEY_NUM{1'b0}};
            active_r <= 1'b0;
            lock_r   <= 1'b0;
        end else begin
            short_r  <= short_nxt_s;
            long_r   <= long_nxt_s;
            repeat_r <= repeat_nxt_s;
            active_r <= (state_nxt_s == PRESSED) || (state_nxt_s == HELD);
            lock_r   <= (state_nxt_s == LOCKED);
        end
    end

    assign kif.key_short  = short_r;
    assign kif.key_long   = long_r;
    assign kif.key_repeat = repeat_r;
    assign kif.key_active = active_r;
    assign kif.key_lock   = lock_r;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl: directed scenarios plus random key
// traffic, every cycle compared against a press-age based reference model.
module tb_key_event_ctrl;

    localparam int LONG   = 100;
    localparam int REPEAT = 20;

    logic sys_clk;
    logic sys_rst_n;
    int   n_tests;
    int   n_fail;

    key_event_ctrl_if kif ();

    key_event_ctrl #(.LONG_CYC(LONG), .REPEAT_CYC(REPEAT), .REPEAT_EN(1'b1)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .kif       (kif)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference model: mode 0 idle, 1 pressed, 2 held, 3 locked;
    // m_age counts cycles since the first pressed cycle.
    int         m_mode;
    int         m_idx;
    int         m_age;
    logic [3:0] e_short, e_long, e_rep;
    logic [3:0] cur_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_age = 0;
        e_short = 4'd0; e_long = 4'd0; e_rep = 4'd0;
    endtask

    task automatic model_step(input logic f, input logic [3:0] v);
        int nz, fi;
        bit same;
        nz = 0; fi = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] == 1'b0) begin nz++; fi = i; end
        end
        e_short = 4'd0; e_long = 4'd0; e_rep = 4'd0;
        same = f && (nz == 1) && (fi == m_idx) && (m_mode == 1 || m_mode == 2);
        case (m_mode)
            0: begin
                if (f && nz == 1) begin m_mode = 1; m_idx = fi; m_age = 0; end
                else if (f && nz >= 2) m_mode = 3;
            end
            1: begin
                if (f && !same) begin
                    if (nz == 0) begin e_short = 4'b0001 << m_idx; m_mode = 0; end
                    else m_mode = 3;
                end else begin
                    if (m_age == LONG - 1) begin e_long = 4'b0001 << m_idx; m_mode = 2; end
                    m_age++;
                end
            end
            2: begin
                if (f && !same) begin
                    m_mode = (nz == 0) ? 0 : 3;
                end else begin
                    if ((m_age - LONG) % REPEAT == REPEAT - 1) e_rep = 4'b0001 << m_idx;
                    m_age++;
                end
            end
            default: begin
                if (f && nz == 0) m_mode = 0;
            end
        endcase
    endtask

    function automatic logic [31:0] dut_vec();
        return {18'd0, kif.key_short, kif.key_long, kif.key_repeat, kif.key_active, kif.key_lock};
    endfunction

    function automatic logic [31:0] exp_vec();
        return {18'd0, e_short, e_long, e_rep, (m_mode == 1 || m_mode == 2), (m_mode == 3)};
    endfunction

    // One clock: apply inputs, advance the model at the edge, compare just after.
    task automatic step(input logic f, input logic [3:0] v);
        kif.key_flag  = f;
        kif.key_value = v;
        cur_val       = v;
        @(posedge sys_clk);
        model_step(f, v);
        #1;
        check("cycle", dut_vec(), exp_vec());
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, cur_val);
    endtask

    int         long_at;
    int         rep_q[$];
    logic [3:0] pulses;
    logic [3:0] rv;

    initial begin
        n_tests = 0; n_fail = 0;
        kif.key_flag = 1'b0; kif.key_value = 4'b1111; cur_val = 4'b1111;
        model_reset();
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_state", dut_vec(), 32'd0);
        sys_rst_n = 1'b1;

        // 1: short press
        step(1'b1, 4'b1110);
        idle(49);
        step(1'b1, 4'b1111);
        check("t1_short", kif.key_short, 4'b0001);
        check("t1_long", kif.key_long, 4'b0000);
        idle(1);
        check("t1_short_once", kif.key_short, 4'b0000);
        idle(3);

        // 2: long press with repeats
        step(1'b1, 4'b1011);
        long_at = -1;
        for (int k = 1; k <= 165; k++) begin
            step(1'b0, cur_val);
            if (kif.key_long != 4'd0) long_at = k;
            if (kif.key_repeat != 4'd0) rep_q.push_back(k);
            if (k == 100) check("t2_long_val", kif.key_long, 4'b0100);
        end
        check("t2_long_cycle", long_at, 100);
        check("t2_rep_count", rep_q.size(), 3);
        for (int i = 0; i < 3; i++)
            check("t2_rep_cycle", (rep_q.size() > i) ? rep_q[i] : -1, 120 + 20 * i);
        step(1'b1, 4'b1111);
        check("t2_no_short", kif.key_short, 4'b0000);
        check("t2_active_fall", kif.key_active, 1'b0);
        idle(3);

        // 3: chord lockout, from PRESSED and directly from IDLE
        pulses = 4'd0;
        step(1'b1, 4'b1110);
        idle(29);
        step(1'b1, 4'b1100);
        check("t3_lock_set", kif.key_lock, 1'b1);
        for (int k = 0; k < 150; k++) begin
            step(1'b0, cur_val);
            pulses = pulses | kif.key_short | kif.key_long | kif.key_repeat;
        end
        check("t3_lock_hold", kif.key_lock, 1'b1);
        step(1'b1, 4'b1111);
        check("t3_lock_clr", kif.key_lock, 1'b0);
        step(1'b1, 4'b0011);
        check("t3_lock_idle", kif.key_lock, 1'b1);
        for (int k = 0; k < 120; k++) begin
            step(1'b0, cur_val);
            pulses = pulses | kif.key_short | kif.key_long | kif.key_repeat;
        end
        step(1'b1, 4'b1111);
        pulses = pulses | kif.key_short | kif.key_long | kif.key_repeat;
        check("t3_no_pulse", pulses, 4'b0000);
        check("t3_lock_clr2", kif.key_lock, 1'b0);
        idle(2);

        // 4: release exactly on the thresholds
        step(1'b1, 4'b1110);
        idle(99);
        step(1'b1, 4'b1111);
        check("t4_tie_short", kif.key_short, 4'b0001);
        check("t4_tie_long", kif.key_long, 4'b0000);
        idle(2);
        step(1'b1, 4'b1110);
        idle(100);
        check("t4_long", kif.key_long, 4'b0001);
        idle(19);
        step(1'b1, 4'b1111);
        check("t4_tie_rep", kif.key_repeat, 4'b0000);
        check("t4_idle", {kif.key_active, kif.key_lock}, 2'b00);
        idle(2);

        // 5: asynchronous reset during a hold on key 3
        step(1'b1, 4'b0111);
        idle(110);
        #3 sys_rst_n = 1'b0;
        #1;
        model_reset();
        check("t5_reset_outs", dut_vec(), 32'd0);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        idle(5);
        step(1'b1, 4'b1111);
        check("t5_idle", kif.key_active, 1'b0);
        step(1'b1, 4'b1110);
        idle(10);
        step(1'b1, 4'b1111);
        check("t5_short", kif.key_short, 4'b0001);
        idle(2);

        // 6: same-pattern re-flag while pressed
        step(1'b1, 4'b1101);
        idle(39);
        step(1'b1, 4'b1101);
        check("t6_still_active", kif.key_active, 1'b1);
        idle(60);
        check("t6_long", kif.key_long, 4'b0010);
        step(1'b1, 4'b1111);
        idle(2);

        // Random key traffic
        for (int e = 0; e < 70; e++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: rv = 4'b1111;
                4, 5, 6, 7: rv = ~(4'b0001 << $urandom_range(0, 3));
                8: begin
                    rv = 4'b1111 & ~(4'b0001 << $urandom_range(0, 3));
                    rv = rv & ~(4'b0001 << $urandom_range(0, 3));
                    if (rv == 4'b1111 || $countones(rv) == 3) rv = 4'b1001;
                end
                default: rv = cur_val;
            endcase
            step(1'b1, rv);
            idle($urandom_range(0, 140));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
Sits downstream of the 4-key debouncer. It converts the debounced key_flag/key_value stream into per-key short-press, long-press and auto-repeat command pulses. These pulses drive the audio record/playback control logic. It enforces single-key operation: multi-key chords are locked out until every key is released.

Parameters:
LONG_CYC, 50_000_000, hold time in sys_clk cycles before a press counts as long (1 s at 50 MHz); must be >= 2.
REPEAT_CYC, 10_000_000, auto-repeat period in cycles after the long pulse (200 ms); must be >= 2.
REPEAT_EN, 1, 1 enables key_repeat pulses; 0 keeps key_repeat at 0.

Ports:
sys_clk  input  1  system clock, 50 MHz
sys_rst_n  input  1  asynchronous reset, active low
key_flag  input  1  one-cycle pulse from the debouncer: key_value has been stable for the debounce time
key_value  input  4  debounced key levels, active low (4'b1111 = nothing pressed)
key_short  output  4  one-cycle pulse, bit i = key i released before LONG_CYC elapsed
key_long  output  4  one-cycle pulse, bit i = key i held for LONG_CYC cycles
key_repeat  output  4  one-cycle pulse every REPEAT_CYC cycles while key i stays held after its long pulse
key_active  output  1  level, high while a valid single key is held (PRESSED or HELD)
key_lock  output  1  level, high in LOCKED state

Behaviour:
- Clock and reset: single clock sys_clk; reset is asynchronous, active-low, on sys_rst_n.
- Reset values: state=IDLE, counter=0, latched key=0, all outputs 0.
- Input sampling: key_value is sampled only in cycles where key_flag=1; it is ignored otherwise.
- Classification of a sampled key_value:
  - REL: equals 4'b1111.
  - ONE: exactly one bit is 0; its index is the key index.
  - MULTI: two or more bits are 0.
- All outputs are registered. Each pulse lasts exactly one cycle and at most one output bit is set per cycle.
- State IDLE:
  - flag & ONE -> PRESSED; latch the key index; counter <= 0.
  - flag & MULTI -> LOCKED.
  - flag & REL -> stay in IDLE.
- State PRESSED (counter increments every cycle):
  - flag & REL -> key_short[idx] pulses on the next cycle; go to IDLE.
  - flag & ONE with the same index -> ignored (re-stabilisation of the same pattern).
  - flag & any other pattern -> LOCKED, no pulse.
  - Otherwise, when counter == LONG_CYC-1 -> key_long[idx] pulses on the next cycle; counter <= 0; go to HELD.
- State HELD (counter increments every cycle):
  - When counter == REPEAT_CYC-1 -> key_repeat[idx] pulses (only if REPEAT_EN); counter <= 0.
  - flag & REL -> IDLE, no key_short.
  - flag & same ONE -> ignored.
  - flag & any other pattern -> LOCKED.
- State LOCKED:
  - Only flag & REL exits, to IDLE. No pulse is ever generated from LOCKED.
- Latency:
  - key_short appears 1 cycle after the releasing key_flag.
  - The first key_long appears LONG_CYC cycles after the first PRESSED cycle.
  - The first key_repeat appears REPEAT_CYC cycles after the key_long cycle.
- Simultaneous events: a key_flag in the same cycle as a counter threshold always wins; no long or repeat pulse is generated in that cycle. A release in PRESSED on the threshold cycle therefore yields key_short.
- Counter: width is clog2(max(LONG_CYC, REPEAT_CYC)). It never wraps, because it is cleared on every threshold and on every state entry.
- key_active = (state==PRESSED or state==HELD); key_lock = (state==LOCKED). Both are registered with the state.
- Reset mid-hold: returns immediately to IDLE with no pulses. A key still held after reset is only recognised at its next key_flag.

Decomposition:
- Shared package key_pkg holds:
  - state enum: IDLE, PRESSED, HELD, LOCKED;
  - KEY_IDLE = 4'b1111;
  - KEY_NUM = 4.
- One sub-module, key_hold_timer: the clear/increment counter with a terminal-count compare output. It is instantiated once, and the active limit (LONG_CYC or REPEAT_CYC) is selected by the FSM.
- One-hot classification and index encoding stay as a combinational function in key_pkg.

Test Plan (LONG_CYC=100, REPEAT_CYC=20, REPEAT_EN=1):
1. Short press: flag with 4'b1110, then flag with 4'b1111 after 50 cycles -> key_short=4'b0001 for 1 cycle, 1 cycle after the release flag; key_long and key_repeat stay 0.
2. Long press and repeat: flag with 4'b1011, held for 165 cycles, then release -> key_long=4'b0100 at cycle 100; key_repeat=4'b0100 at cycles 120, 140 and 160; no key_short on release; key_active falls 1 cycle after the release flag.
3. Chord lockout: flag with 4'b1110, then flag with 4'b1100 at cycle 30, then flag with 4'b1111 -> key_lock=1 until 1 cycle after the release flag; no pulses at all. Repeat the test starting from 4'b0011 directly in IDLE: same result.
4. Boundary tie: release flag exactly on the cycle the counter reaches 99 -> key_short=4'b0001; key_long stays 0. In HELD, release on counter 19 -> no key_repeat, state returns to IDLE.
5. Reset mid-operation: assert sys_rst_n=0 asynchronously at cycle 110 of a hold on key 3 -> all outputs 0 immediately; state IDLE after release; the next short press works normally.
6. Same-pattern re-flag: in PRESSED on key 1, a second flag with 4'b1101 at cycle 40 -> ignored; key_long still arrives at cycle 100.
